// File: rtl/phase_sequencer.sv
// Programmable multi-phase interval sequencer: one mod-N counter whose
// terminal value changes per phase, advanced by an external tick strobe.
module phase_sequencer #(
  parameter int BITS   = 4,
  parameter int PHASES = 4,
  parameter int PW     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic                     loop,
  input  logic                     tick,
  input  logic [PHASES*BITS-1:0]   final_values,
  output logic [BITS-1:0]          count,
  output logic [PW-1:0]            phase,
  output logic                     busy,
  output logic                     phase_end,
  output logic                     done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;

  logic [1:0]      state;
  logic [BITS-1:0] fin [PHASES];
  logic [BITS-1:0] cur_final;
  logic            last_phase;

  assign cur_final  = fin[phase];
  assign last_phase = (phase == PW'(PHASES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      phase     <= '0;
      busy      <= 1'b0;
      phase_end <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < PHASES; i++) fin[i] <= '0;
    end else begin
      phase_end <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          phase <= '0;
          // Terminal values are captured once so later bus changes cannot
          // disturb a running sequence.
          if (start && !stop) begin
            for (int i = 0; i < PHASES; i++)
              fin[i] <= final_values[i*BITS +: BITS];
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
            phase <= '0;
          end else if (pause) begin
            state <= PAUSED;
          end else if (tick) begin
            if (count != cur_final) begin
              count <= count + BITS'(1);
            end else begin
              count     <= '0;
              phase_end <= 1'b1;
              if (!last_phase) begin
                phase <= phase + PW'(1);
              end else begin
                phase <= '0;
                if (!loop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end
          end
        end
        PAUSED: begin
          // A tick on the edge where pause falls is deliberately dropped.
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
            phase <= '0;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
          phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus random
// traffic, compared each cycle against a tick-elapsed reference model.
module tb_phase_sequencer;

  localparam int BITS   = 4;
  localparam int PHASES = 4;
  localparam int PW     = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic                   stop = 1'b0;
  logic                   pause = 1'b0;
  logic                   loop = 1'b0;
  logic                   tick = 1'b0;
  logic [PHASES*BITS-1:0] final_values = '0;
  logic [BITS-1:0]        count;
  logic [PW-1:0]          phase;
  logic                   busy;
  logic                   phase_end;
  logic                   done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a sequence is a run of sum(fin[i]+1) accepted ticks;
  // phase and count are derived from how many ticks have elapsed.
  int m_fin [PHASES];
  int m_elapsed;
  bit m_active;
  bit m_paused;
  bit exp_pe;
  bit exp_done;
  int pe_seen;
  int done_seen;

  phase_sequencer #(.BITS(BITS), .PHASES(PHASES), .PW(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .loop(loop), .tick(tick), .final_values(final_values), .count(count),
    .phase(phase), .busy(busy), .phase_end(phase_end), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int total_len();
    int s = 0;
    for (int i = 0; i < PHASES; i++) s += m_fin[i] + 1;
    return s;
  endfunction

  function automatic bit on_boundary(input int e);
    int s = 0;
    for (int i = 0; i < PHASES; i++) begin
      s += m_fin[i] + 1;
      if (s == e) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_pos(output int mc, output int mp);
    int rem = m_elapsed;
    int p = 0;
    while (p < PHASES && rem >= m_fin[p] + 1) begin
      rem -= m_fin[p] + 1;
      p++;
    end
    mc = rem;
    mp = p;
  endtask

  task automatic model_step();
    exp_pe   = 1'b0;
    exp_done = 1'b0;
    if (reset) begin
      m_active = 0; m_paused = 0; m_elapsed = 0;
      for (int i = 0; i < PHASES; i++) m_fin[i] = 0;
    end else if (!m_active) begin
      if (start && !stop) begin
        m_active = 1; m_paused = 0; m_elapsed = 0;
        for (int i = 0; i < PHASES; i++) m_fin[i] = int'(final_values[i*BITS +: BITS]);
      end
    end else if (stop) begin
      m_active = 0; m_paused = 0; m_elapsed = 0;
    end else if (m_paused) begin
      if (!pause) m_paused = 0;
    end else if (pause) begin
      m_paused = 1;
    end else if (tick) begin
      m_elapsed++;
      if (on_boundary(m_elapsed)) exp_pe = 1'b1;
      if (m_elapsed == total_len()) begin
        m_elapsed = 0;
        if (!loop) begin
          m_active = 0;
          exp_done = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    int mc, mp;
    model_step();
    @(posedge clk);
    #1;
    model_pos(mc, mp);
    check("count", int'(count), mc);
    check("phase", int'(phase), mp);
    check("busy", int'(busy), int'(m_active));
    check("phase_end", int'(phase_end), int'(exp_pe));
    check("done", int'(done), int'(exp_done));
    if (phase_end) pe_seen++;
    if (done) done_seen++;
  endtask

  task automatic set_in(input bit st, input bit sp, input bit pa, input bit tk);
    start = st; stop = sp; pause = pa; tick = tk;
  endtask

  initial begin
    m_active = 0; m_paused = 0; m_elapsed = 0;
    for (int i = 0; i < PHASES; i++) m_fin[i] = 0;

    // Reset state, with start asserted to confirm reset wins.
    reset = 1'b1; start = 1'b1; tick = 1'b1;
    step(); step();
    reset = 1'b0;
    set_in(0, 0, 0, 0);
    step();

    // 1: finals {3,1,0,2}, no loop -> 10 ticks, 4 phase_end, 1 done.
    final_values = 16'h2013; loop = 1'b0;
    pe_seen = 0; done_seen = 0;
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step();
    check("t1_pe_count", pe_seen, 4);
    check("t1_done_count", done_seen, 1);
    check("t1_idle_busy", int'(busy), 0);

    // 2: same with loop -> two full passes, no done.
    loop = 1'b1; pe_seen = 0; done_seen = 0;
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step();
    check("t2_pe_count", pe_seen, 8);
    check("t2_done_count", done_seen, 0);
    check("t2_still_busy", int'(busy), 1);
    set_in(0, 1, 0, 0); step();
    loop = 1'b0;

    // 3: pause at count 2 of phase 0 with ticks present.
    final_values = 16'h2013;
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 0, 1); step(); step();
    check("t3_count_before", int'(count), 2);
    set_in(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step();
    check("t3_count_held", int'(count), 2);
    set_in(0, 0, 0, 1); step();
    check("t3_tick_dropped", int'(count), 2);
    step();
    check("t3_resumed", int'(count), 3);
    set_in(0, 1, 0, 0); step();

    // 4: stop with tick mid phase 2, then reset mid-run.
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step();
    check("t4_in_phase2", int'(phase), 2);
    set_in(0, 1, 0, 1); step();
    check("t4_stop_busy", int'(busy), 0);
    set_in(0, 0, 0, 1); step();
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 0, 1); step(); step(); step();
    reset = 1'b1; step();
    reset = 1'b0; step();

    // 5: finals change and start while busy are ignored; all-15 finals.
    final_values = 16'hFFFF; pe_seen = 0; done_seen = 0;
    set_in(1, 0, 0, 0); step();
    final_values = 16'h0000;
    set_in(1, 0, 0, 1);
    for (int i = 0; i < 15; i++) step();
    check("t5_count15", int'(count), 15);
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 52; i++) step();
    check("t5_pe_count", pe_seen, 4);
    check("t5_done_count", done_seen, 1);

    // 6: start and stop together in idle.
    set_in(1, 1, 0, 1); step(); step();
    check("t6_busy", int'(busy), 0);
    set_in(0, 0, 0, 0); step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      tick  = $urandom_range(0, 1) != 0;
      loop  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      final_values = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
